// File: rtl/tomasulo_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : tomasulo_reservation_station
//  Purpose  : Reservation station feeding one functional unit. Holds dispatched
//             instructions, captures pending operands from the CDB and offers
//             ready instructions to the FU over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tomasulo_reservation_station #(
    parameter int N_ENTRIES = 4,
    parameter int N_SIZE    = 16,
    parameter int TAG_W     = 3,
    parameter int OP_W      = 4,
    parameter int OCC_W     = $clog2(N_ENTRIES + 1)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [N_SIZE-1:0] disp_vj,
    input  logic [N_SIZE-1:0] disp_vk,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic              disp_qj_busy,
    input  logic              disp_qk_busy,
    input  logic [TAG_W-1:0]  disp_dest_tag,

    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [N_SIZE-1:0] cdb_data,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OP_W-1:0]   ex_op,
    output logic [N_SIZE-1:0] ex_a,
    output logic [N_SIZE-1:0] ex_b,
    output logic [TAG_W-1:0]  ex_dest_tag,

    output logic [OCC_W-1:0]  occupancy
);

    localparam int c_IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    // Slot control state (reset) and payload state (no reset needed).
    logic [N_ENTRIES-1:0] r_busy;
    logic [N_ENTRIES-1:0] r_qj_busy;
    logic [N_ENTRIES-1:0] r_qk_busy;
    logic [OP_W-1:0]      r_op   [N_ENTRIES];
    logic [N_SIZE-1:0]    r_vj   [N_ENTRIES];
    logic [N_SIZE-1:0]    r_vk   [N_ENTRIES];
    logic [TAG_W-1:0]     r_qj   [N_ENTRIES];
    logic [TAG_W-1:0]     r_qk   [N_ENTRIES];
    logic [TAG_W-1:0]     r_dest [N_ENTRIES];

    logic                 r_lock_valid;
    logic [c_IDX_W-1:0]   r_lock_idx;
    logic [OCC_W-1:0]     r_occ;

    logic [N_ENTRIES-1:0] w_slot_ready;
    logic                 w_any_ready;
    logic [c_IDX_W-1:0]   w_cand_idx;
    logic                 w_any_free;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic                 w_issue;
    logic                 w_disp;

    logic                 w_byp_j;
    logic                 w_byp_k;
    logic [N_SIZE-1:0]    w_disp_vj;
    logic [N_SIZE-1:0]    w_disp_vk;

    generate
        for (genvar g = 0; g < N_ENTRIES; g++) begin : g_slot_ready
            assign w_slot_ready[g] = r_busy[g] & ~r_qj_busy[g] & ~r_qk_busy[g];
        end
    endgenerate

    // Lowest-index ready slot and lowest-index free slot; scanning downwards
    // lets the lowest index overwrite any higher match.
    always_comb begin
        w_any_ready = 1'b0;
        w_cand_idx  = '0;
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (w_slot_ready[i]) begin
                w_any_ready = 1'b1;
                w_cand_idx  = c_IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_sel_idx   = r_lock_valid ? r_lock_idx : w_cand_idx;

    assign ex_valid    = ~reset & (r_lock_valid | w_any_ready);
    assign ex_op       = r_op[w_sel_idx];
    assign ex_a        = r_vj[w_sel_idx];
    assign ex_b        = r_vk[w_sel_idx];
    assign ex_dest_tag = r_dest[w_sel_idx];

    assign disp_ready  = ~reset & w_any_free;
    assign occupancy   = r_occ;

    assign w_issue     = ex_valid & ex_ready;
    assign w_disp      = disp_valid & disp_ready;

    // A broadcast in the dispatch cycle is captured directly into the new slot.
    assign w_byp_j     = cdb_valid & disp_qj_busy & (cdb_tag == disp_qj);
    assign w_byp_k     = cdb_valid & disp_qk_busy & (cdb_tag == disp_qk);
    assign w_disp_vj   = w_byp_j ? cdb_data : disp_vj;
    assign w_disp_vk   = w_byp_k ? cdb_data : disp_vk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= '0;
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
            r_occ        <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (w_issue && (w_sel_idx == c_IDX_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end else if (w_disp && (w_free_idx == c_IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end
            end

            if (w_issue) begin
                r_lock_valid <= 1'b0;
            end else if (ex_valid) begin
                r_lock_valid <= 1'b1;
                r_lock_idx   <= w_sel_idx;
            end

            r_occ <= r_occ + OCC_W'(w_disp) - OCC_W'(w_issue);
        end
    end

    // Payload: the dispatch target is never busy, so dispatch and snoop
    // never touch the same slot in one cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (w_disp && (w_free_idx == c_IDX_W'(i))) begin
                r_op[i]      <= disp_op;
                r_vj[i]      <= w_disp_vj;
                r_vk[i]      <= w_disp_vk;
                r_qj[i]      <= disp_qj;
                r_qk[i]      <= disp_qk;
                r_qj_busy[i] <= disp_qj_busy & ~w_byp_j;
                r_qk_busy[i] <= disp_qk_busy & ~w_byp_k;
                r_dest[i]    <= disp_dest_tag;
            end else if (r_busy[i] && cdb_valid) begin
                if (r_qj_busy[i] && (r_qj[i] == cdb_tag)) begin
                    r_vj[i]      <= cdb_data;
                    r_qj_busy[i] <= 1'b0;
                end
                if (r_qk_busy[i] && (r_qk[i] == cdb_tag)) begin
                    r_vk[i]      <= cdb_data;
                    r_qk_busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tomasulo_reservation_station
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             compared every cycle against a slot-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tomasulo_reservation_station;

    localparam int N = 4;
    localparam int W = 16;
    localparam int T = 3;
    localparam int O = 4;
    localparam int OC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_valid, disp_ready;
    logic [O-1:0]  disp_op;
    logic [W-1:0]  disp_vj, disp_vk;
    logic [T-1:0]  disp_qj, disp_qk, disp_dest_tag;
    logic          disp_qj_busy, disp_qk_busy;
    logic          cdb_valid;
    logic [T-1:0]  cdb_tag;
    logic [W-1:0]  cdb_data;
    logic          ex_valid, ex_ready;
    logic [O-1:0]  ex_op;
    logic [W-1:0]  ex_a, ex_b;
    logic [T-1:0]  ex_dest_tag;
    logic [OC-1:0] occupancy;

    always #5 clk = ~clk;

    tomasulo_reservation_station #(
        .N_ENTRIES(N), .N_SIZE(W), .TAG_W(T), .OP_W(O), .OCC_W(OC)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_dest_tag(disp_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_dest_tag(ex_dest_tag),
        .occupancy(occupancy)
    );

    typedef struct {
        bit           busy;
        logic [O-1:0] op;
        logic [W-1:0] vj, vk;
        logic [T-1:0] qj, qk, dest;
        bit           qjb, qkb;
    } slot_t;

    slot_t m[N];
    int    held;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_offer();
        if (held >= 0) return held;
        for (int i = 0; i < N; i++)
            if (m[i].busy && !m[i].qjb && !m[i].qkb) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m[i].busy) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        held = -1;
    endtask

    // Applies one clock edge's worth of spec rules to the model.
    task automatic model_step();
        int    off, fr;
        bit    issue;
        slot_t s;
        if (reset) begin
            model_clear();
            return;
        end
        off   = m_offer();
        issue = (off >= 0) && ex_ready;
        fr    = -1;
        for (int i = N - 1; i >= 0; i--) if (!m[i].busy) fr = i;
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && cdb_valid) begin
                if (m[i].qjb && m[i].qj == cdb_tag) begin m[i].vj = cdb_data; m[i].qjb = 0; end
                if (m[i].qkb && m[i].qk == cdb_tag) begin m[i].vk = cdb_data; m[i].qkb = 0; end
            end
        end
        if (issue) begin
            m[off].busy = 0;
            held = -1;
        end else if (off >= 0) begin
            held = off;
        end
        if (disp_valid && fr >= 0) begin
            s.busy = 1;
            s.op   = disp_op;
            s.qj   = disp_qj;
            s.qk   = disp_qk;
            s.dest = disp_dest_tag;
            s.qjb  = disp_qj_busy;
            s.qkb  = disp_qk_busy;
            s.vj   = disp_vj;
            s.vk   = disp_vk;
            if (cdb_valid && s.qjb && cdb_tag == s.qj) begin s.vj = cdb_data; s.qjb = 0; end
            if (cdb_valid && s.qkb && cdb_tag == s.qk) begin s.vk = cdb_data; s.qkb = 0; end
            m[fr] = s;
        end
    endtask

    // Called just after a falling edge with inputs set: compare, clock, update.
    task automatic cycle();
        int off;
        bit ev;
        #1;
        off = m_offer();
        ev  = !reset && (off >= 0);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, ev});
        chk("disp_ready", {31'd0, disp_ready}, {31'd0, (!reset && m_count() < N)});
        chk("occupancy", {29'd0, occupancy}, m_count());
        if (ev) begin
            chk("ex_op", {28'd0, ex_op}, {28'd0, m[off].op});
            chk("ex_a", {16'd0, ex_a}, {16'd0, m[off].vj});
            chk("ex_b", {16'd0, ex_b}, {16'd0, m[off].vk});
            chk("ex_dest_tag", {29'd0, ex_dest_tag}, {29'd0, m[off].dest});
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset      = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic disp(input logic [O-1:0] op, input logic [W-1:0] vj, input logic [W-1:0] vk,
                        input logic [T-1:0] qj, input bit qjb, input logic [T-1:0] qk,
                        input bit qkb, input logic [T-1:0] dest);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_vj       = vj;
        disp_vk       = vk;
        disp_qj       = qj;
        disp_qj_busy  = qjb;
        disp_qk       = qk;
        disp_qk_busy  = qkb;
        disp_dest_tag = dest;
    endtask

    task automatic cdb(input logic [T-1:0] tag, input logic [W-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        disp_valid = 0; disp_op = 0; disp_vj = 0; disp_vk = 0;
        disp_qj = 0; disp_qk = 0; disp_qj_busy = 0; disp_qk_busy = 0; disp_dest_tag = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; ex_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_disp_ready", {31'd0, disp_ready}, 32'd0);

        // Release: free slot visible in the first cycle.
        idle();
        #1;
        chk("post_reset_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("post_reset_occ", {29'd0, occupancy}, 32'd0);
        @(negedge clk);

        // Ready operands straight through.
        ex_ready = 1'b1;
        disp(4'd3, 16'h0011, 16'h0022, 3'd0, 0, 3'd0, 0, 3'd6);
        cycle();
        chk("basic_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("basic_ex_a", {16'd0, ex_a}, 32'h0011);
        chk("basic_ex_b", {16'd0, ex_b}, 32'h0022);
        chk("basic_ex_op", {28'd0, ex_op}, 32'd3);
        chk("basic_occ1", {29'd0, occupancy}, 32'd1);
        idle();
        cycle();
        chk("basic_occ0", {29'd0, occupancy}, 32'd0);

        // Pending j operand woken by a later broadcast.
        disp(4'd5, 16'h0000, 16'h0007, 3'd5, 1, 3'd0, 0, 3'd1);
        cycle();
        idle();
        cycle();
        chk("wait_ex_valid_low", {31'd0, ex_valid}, 32'd0);
        cdb(3'd5, 16'hBEEF);
        cycle();
        chk("cdb_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("cdb_ex_a", {16'd0, ex_a}, 32'hBEEF);
        idle();
        cycle();

        // Dispatch-time bypass on k.
        disp(4'd7, 16'h0009, 16'h0000, 3'd0, 0, 3'd2, 1, 3'd3);
        cdb(3'd2, 16'h1234);
        cycle();
        chk("bypass_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("bypass_ex_b", {16'd0, ex_b}, 32'h1234);
        idle();
        cycle();

        // Fill to capacity with the FU stalled; fifth dispatch dropped.
        ex_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            disp(4'(i), 16'h0100 + 16'(i), 16'h0, 3'd0, 0, 3'd0, 0, 3'(i));
            cycle();
        end
        chk("full_disp_ready", {31'd0, disp_ready}, 32'd0);
        chk("full_occ", {29'd0, occupancy}, 32'd4);
        disp(4'd9, 16'hDEAD, 16'h0, 3'd0, 0, 3'd0, 0, 3'd0);
        cycle();
        chk("full_drop_occ", {29'd0, occupancy}, 32'd4);
        idle();
        ex_ready = 1'b1;
        cycle();
        chk("unfull_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("unfull_occ", {29'd0, occupancy}, 32'd3);
        chk("unfull_next_a", {16'd0, ex_a}, 32'h0101);
        repeat (3) cycle();
        chk("drained_occ", {29'd0, occupancy}, 32'd0);

        // Offer lock on slot 2 survives slot 0 becoming ready.
        ex_ready = 1'b0;
        disp(4'd1, 16'h0, 16'h0A0A, 3'd1, 1, 3'd0, 0, 3'd0);
        cycle();
        disp(4'd2, 16'h0, 16'h0B0B, 3'd4, 1, 3'd0, 0, 3'd1);
        cycle();
        disp(4'd4, 16'h2222, 16'h0C0C, 3'd0, 0, 3'd0, 0, 3'd2);
        cycle();
        idle();
        chk("lock_offer_a", {16'd0, ex_a}, 32'h2222);
        cdb(3'd1, 16'h0AAA);
        cycle();
        idle();
        chk("lock_hold_a1", {16'd0, ex_a}, 32'h2222);
        cycle();
        chk("lock_hold_a2", {16'd0, ex_a}, 32'h2222);
        chk("lock_hold_dest", {29'd0, ex_dest_tag}, 32'd2);
        ex_ready = 1'b1;
        cycle();
        chk("lock_next_a", {16'd0, ex_a}, 32'h0AAA);
        cdb(3'd4, 16'h0444);
        cycle();
        idle();
        chk("lock_last_a", {16'd0, ex_a}, 32'h0444);
        cycle();
        chk("lock_drained_occ", {29'd0, occupancy}, 32'd0);

        // Reset while occupied with a pending offer.
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(4'd8, 16'h3000 + 16'(i), 16'h0, 3'd0, 0, 3'd0, 0, 3'd5);
            cycle();
        end
        idle();
        cycle();
        reset = 1'b1;
        #1;
        chk("midreset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midreset_disp_ready", {31'd0, disp_ready}, 32'd0);
        cycle();
        reset = 1'b0;
        chk("after_reset_occ", {29'd0, occupancy}, 32'd0);
        #1;
        chk("after_reset_disp_ready", {31'd0, disp_ready}, 32'd1);
        @(negedge clk);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 6)
                disp(4'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                     $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 1) == 1,
                     3'($urandom));
            else
                disp_valid = 1'b0;
            cdb_valid = $urandom_range(0, 1) == 1;
            cdb_tag   = 3'($urandom);
            cdb_data  = 16'($urandom);
            ex_ready  = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tomasulo_reservation_station.md
Name: tomasulo_reservation_station

Overview:
- Reservation station between issue/register-read and one functional unit (FU) of the Tomasulo core.
- Accepts an instruction with operand values from the register file, or with producer tags for operands still in flight.
- Captures pending operands by snooping the common data bus (CDB) and hands fully-ready instructions to the FU over a valid/ready handshake.

Parameters:
- N_ENTRIES, 4, number of station slots (power of two, ≥2).
- N_SIZE, 16, operand/data width (matches register file).
- TAG_W, 3, producer tag width.
- OP_W, 4, opcode width.
- OCC_W, $clog2(N_ENTRIES+1), occupancy counter width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- disp_valid, input, 1, dispatch request.
- disp_ready, output, 1, a free slot exists.
- disp_op, input, OP_W, opcode.
- disp_vj / disp_vk, input, N_SIZE, operand values from the register file (Rn/Rm).
- disp_qj / disp_qk, input, TAG_W, producer tag when the operand is pending.
- disp_qj_busy / disp_qk_busy, input, 1, 1 = operand pending (value invalid, wait on tag).
- disp_dest_tag, input, TAG_W, tag this instruction broadcasts on completion.
- cdb_valid, input, 1, CDB broadcast this cycle.
- cdb_tag, input, TAG_W, broadcasting producer tag.
- cdb_data, input, N_SIZE, broadcast result.
- ex_valid, output, 1, ready instruction offered to the FU.
- ex_ready, input, 1, FU accepts.
- ex_op, output, OP_W, opcode.
- ex_a / ex_b, output, N_SIZE, operands j/k.
- ex_dest_tag, output, TAG_W, destination tag.
- occupancy, output, OCC_W, number of occupied slots.

Behaviour:
- Reset (sync, active-high):
  - All slots FREE; selection lock cleared; occupancy = 0.
  - While reset is high, disp_ready = 0 and ex_valid = 0.
  - After release, disp_ready = 1 in the first cycle.
  - Reset mid-operation discards all slots and any held offer; the FU must ignore an unaccepted offer across reset.
- Slot state per entry: busy, op, vj, vk, qj, qk, qj_busy, qk_busy, dest_tag. A slot is READY when busy & !qj_busy & !qk_busy, evaluated on registered state.
- Dispatch:
  - disp_ready = any slot not busy, computed from registered state only; a slot freed this cycle is reusable next cycle.
  - On disp_valid & disp_ready, write the lowest-index free slot at the clock edge.
  - disp_valid while !disp_ready is ignored; no slot is written.
- Dispatch-time CDB bypass:
  - If cdb_valid and disp_qj_busy and cdb_tag == disp_qj in the same cycle, store vj = cdb_data and qj_busy = 0.
  - Same rule for k, independently; both may capture the same broadcast.
- CDB snoop:
  - Each busy slot with qj_busy and qj == cdb_tag (cdb_valid = 1) captures cdb_data into vj and clears qj_busy at the edge; same for k.
  - A slot made READY by the CDB becomes eligible the following cycle (no same-cycle CDB→FU forwarding).
- Issue selection:
  - When no lock is held, the candidate is the lowest-index READY slot.
  - ex_valid = lock held OR any READY slot; ex_* = fields of the locked slot if a lock is held, else of the candidate.
  - If ex_valid & !ex_ready, the lock is set to the offered slot index. Payload and ex_valid stay stable until accepted, even if a lower-index slot becomes READY.
  - On ex_valid & ex_ready: the slot is freed and the lock cleared at the edge.
- Simultaneous events:
  - Dispatch and issue in the same cycle are both performed; occupancy is unchanged.
  - Dispatch never targets the slot being freed in the same cycle.
  - CDB snoop on a slot that is being issued has no effect (operands already valid).
- Occupancy: +1 on dispatch, −1 on issue, net 0 when both occur. It never exceeds N_ENTRIES and never underflows.
- Tag 0 carries no special meaning; operand validity is decided solely by the *_busy bits.

Test Plan:
- Reset then dispatch op=3, vj=0x0011, vk=0x0022, both not busy, ex_ready=1 → ex_valid=1 the next cycle with ex_a=0x0011, ex_b=0x0022, ex_op=3; occupancy goes 1 then 0.
- Dispatch with qj=5 busy; two cycles later cdb_valid, tag=5, data=0xBEEF → ex_valid rises the cycle after the broadcast, ex_a=0xBEEF.
- Dispatch with qk=2 busy while cdb_valid, tag=2, data=0x1234 in the same cycle → slot READY immediately; ex_b=0x1234 the next cycle.
- Hold ex_ready=0 and fill 4 slots → disp_ready=0, occupancy=4, and a 5th disp_valid is dropped. Then pulse ex_ready=1 for one cycle → disp_ready=1 the following cycle.
- Slot 2 is offered with ex_ready=0; slot 0 then becomes READY via the CDB → ex outputs stay on slot 2 until accepted, then slot 0 is offered.
- Assert reset while 3 slots are occupied and an offer is pending → ex_valid=0 and disp_ready=0 during reset; occupancy=0 and disp_ready=1 after release.
